// File: rtl/imem_responder.sv
// imem_responder: memory end of the instruction-fetch interface.
//   Accepts byte-PC fetch requests over a valid/ready channel and returns the
//   32-bit word after LATENCY wait cycles. Misaligned or out-of-range fetches
//   complete with rsp_err=1 and rsp_instr=0. A word write port preloads text.
// Ports:
//   clk, reset (async, active-low)
//   req_valid/req_ready/req_addr        fetch request channel
//   rsp_valid/rsp_ready                 response handshake
//   rsp_instr/rsp_addr/rsp_err          response payload (held when not valid)
//   wr_en/wr_addr/wr_data               word write port, active in every state
//   flush (only with IMEM_FLUSH_EN)     synchronous abort of WAIT/RESP
// Optional feature macro: IMEM_FLUSH_EN
module imem_responder #(
  parameter int unsigned DEPTH_LOG2 = 12,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_3000,
  parameter int unsigned LATENCY    = 0
) (
  input  logic        clk,
  input  logic        reset,
`ifdef IMEM_FLUSH_EN
  input  logic        flush,
`endif
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_instr,
  output logic [31:0] rsp_addr,
  output logic        rsp_err,
  input  logic        wr_en,
  input  logic [31:0] wr_addr,
  input  logic [31:0] wr_data
);

  localparam int unsigned DEPTH    = 1 << DEPTH_LOG2;
  // End of the window is 33 bits so a window touching 2^32 does not wrap.
  localparam logic [32:0] END_ADDR = {1'b0, BASE_ADDR} + (33'd4 << DEPTH_LOG2);
  localparam logic [2:0]  LOAD_CNT = (LATENCY > 0) ? 3'(LATENCY - 1) : 3'd0;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_e;

  function automatic logic addr_err(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a < BASE_ADDR) || ({1'b0, a} >= END_ADDR);
  endfunction

  function automatic logic [DEPTH_LOG2-1:0] word_index(input logic [31:0] a);
    return DEPTH_LOG2'((a - BASE_ADDR) >> 2);
  endfunction

  logic [31:0] mem_q [DEPTH];

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] addr_q, addr_d;
  logic        err_q, err_d;

  logic        flush_w;
  logic        accept;
  logic        rd_err;
  logic [31:0] rd_word;
  logic        wr_err;

`ifdef IMEM_FLUSH_EN
  assign flush_w = flush;
`else
  assign flush_w = 1'b0;
`endif

  assign rd_err  = addr_err(req_addr);
  assign wr_err  = addr_err(wr_addr);
  // Combinational read of the pre-edge contents gives read-before-write
  // when a write hits the same word on the accept edge.
  assign rd_word = mem_q[word_index(req_addr)];

  assign req_ready = ((state_q == ST_IDLE) || ((state_q == ST_RESP) && rsp_ready)) && !flush_w;
  assign accept    = req_valid && req_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    instr_d = instr_q;
    addr_d  = addr_q;
    err_d   = err_q;

    case (state_q)
      ST_WAIT: begin
        if (cnt_q == 3'd0) state_d = ST_RESP;
        else               cnt_d   = cnt_q - 3'd1;
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = state_q;
    endcase

    // Accept overrides the RESP->IDLE step so back-to-back fetches chain.
    if (accept) begin
      addr_d  = req_addr;
      err_d   = rd_err;
      instr_d = rd_err ? '0 : rd_word;
      if (LATENCY == 0) begin
        state_d = ST_RESP;
      end else begin
        state_d = ST_WAIT;
        cnt_d   = LOAD_CNT;
      end
    end

    if (flush_w) state_d = ST_IDLE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      instr_q <= '0;
      addr_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      instr_q <= instr_d;
      addr_q  <= addr_d;
      err_q   <= err_d;
    end
  end

  // Memory is not reset; contents survive a reset pulse.
  always_ff @(posedge clk) begin
    if (wr_en && !wr_err) mem_q[word_index(wr_addr)] <= wr_data;
  end

  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_instr = instr_q;
  assign rsp_addr  = addr_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder: three instances (LATENCY 0, 3, 5) share one
// stimulus stream; each is compared every cycle against a transaction-level
// model (due-cycle of the pending fetch, word array, plain address arithmetic).
module tb_imem_responder;

  localparam int NDUT = 3;
  localparam longint BASE = 'h3000;
  localparam longint NWORDS = 4096;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        flush = 1'b0;
  logic        req_valid = 1'b0;
  logic [31:0] req_addr = '0;
  logic        rsp_ready = 1'b0;
  logic        wr_en = 1'b0;
  logic [31:0] wr_addr = '0;
  logic [31:0] wr_data = '0;

  logic        req_ready [NDUT];
  logic        rsp_valid [NDUT];
  logic [31:0] rsp_instr [NDUT];
  logic [31:0] rsp_addr  [NDUT];
  logic        rsp_err   [NDUT];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int unsigned LAT = (g == 0) ? 0 : ((g == 1) ? 3 : 5);
    imem_responder #(
      .DEPTH_LOG2(12),
      .BASE_ADDR (32'h0000_3000),
      .LATENCY   (LAT)
    ) u_dut (
      .clk      (clk),
      .reset    (reset),
`ifdef IMEM_FLUSH_EN
      .flush    (flush),
`endif
      .req_valid(req_valid),
      .req_ready(req_ready[g]),
      .req_addr (req_addr),
      .rsp_valid(rsp_valid[g]),
      .rsp_ready(rsp_ready),
      .rsp_instr(rsp_instr[g]),
      .rsp_addr (rsp_addr[g]),
      .rsp_err  (rsp_err[g]),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data)
    );
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Reference model
  longint      lat [NDUT] = '{0, 3, 5};
  bit          m_have [NDUT];
  longint      m_due  [NDUT];
  logic [31:0] m_instr [NDUT];
  logic [31:0] m_addr  [NDUT];
  bit          m_err   [NDUT];
  logic [31:0] mmem [NWORDS];
  longint      cyc = 0;

  function automatic bit bad_addr(input logic [31:0] a);
    longint x;
    x = {32'b0, a};
    return (x % 4 != 0) || (x < BASE) || (x >= BASE + 4 * NWORDS);
  endfunction

  function automatic int word_of(input logic [31:0] a);
    longint x;
    x = {32'b0, a};
    return int'((x - BASE) / 4);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NDUT; i++) begin
      m_have[i] = 0; m_due[i] = 0; m_instr[i] = '0; m_addr[i] = '0; m_err[i] = 0;
    end
  endtask

  // Called just after a negedge with inputs already driven; checks, advances
  // the model across the next rising edge and returns at the next negedge.
  task automatic tick();
    bit fl, ev, er;
    #1;
    fl = 0;
`ifdef IMEM_FLUSH_EN
    fl = flush;
`endif
    for (int i = 0; i < NDUT; i++) begin
      ev = m_have[i] && (cyc >= m_due[i]);
      er = (!m_have[i] || (ev && rsp_ready)) && !fl;
      check($sformatf("u%0d.req_ready", i), {31'b0, req_ready[i]}, {31'b0, er});
      check($sformatf("u%0d.rsp_valid", i), {31'b0, rsp_valid[i]}, {31'b0, ev});
      check($sformatf("u%0d.rsp_instr", i), rsp_instr[i], m_instr[i]);
      check($sformatf("u%0d.rsp_addr", i), rsp_addr[i], m_addr[i]);
      check($sformatf("u%0d.rsp_err", i), {31'b0, rsp_err[i]}, {31'b0, m_err[i]});
      if (ev && rsp_ready) m_have[i] = 0;
      if (req_valid && er) begin
        m_have[i]  = 1;
        m_due[i]   = cyc + lat[i] + 1;
        m_addr[i]  = req_addr;
        m_err[i]   = bad_addr(req_addr);
        m_instr[i] = m_err[i] ? 32'h0 : mmem[word_of(req_addr)];
      end
      if (fl) m_have[i] = 0;
    end
    if (wr_en && !bad_addr(wr_addr)) mmem[word_of(wr_addr)] = wr_data;
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle_ticks(input int n);
    req_valid = 0; wr_en = 0; rsp_ready = 1; flush = 0;
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic write_word(input logic [31:0] a, input logic [31:0] d);
    req_valid = 0; wr_en = 1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 0;
  endtask

  task automatic fetch_one(input logic [31:0] a);
    req_valid = 1; req_addr = a; rsp_ready = 1;
    tick();
    req_valid = 0;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    case ($urandom_range(0, 9))
      0, 1, 2, 3, 4, 5: a = 32'h3000 + 32'd4 * $urandom_range(0, 4095);
      6:       a = 32'h3000 + 32'd4 * $urandom_range(0, 4095) + $urandom_range(1, 3);
      7:       a = $urandom_range(0, 32'h2fff);
      8:       a = 32'h7000 + 32'd4 * $urandom_range(0, 1000);
      default: a = ($urandom_range(0, 1) == 1) ? 32'h6ffc : 32'hffff_fffc;
    endcase
    return a;
  endfunction

  logic [31:0] err_addrs [4] = '{32'h3002, 32'h2ffc, 32'h7000, 32'h6ffc};
  logic        err_exp   [4] = '{1'b1, 1'b1, 1'b1, 1'b0};

  initial begin
    model_clear();
    repeat (2) @(negedge clk);
    #1;
    for (int i = 0; i < NDUT; i++) begin
      check($sformatf("rst.u%0d.valid", i), {31'b0, rsp_valid[i]}, 32'h0);
      check($sformatf("rst.u%0d.instr", i), rsp_instr[i], 32'h0);
      check($sformatf("rst.u%0d.addr", i), rsp_addr[i], 32'h0);
      check($sformatf("rst.u%0d.err", i), {31'b0, rsp_err[i]}, 32'h0);
    end
    @(negedge clk);
    reset = 1;

    // Preload every word so later reads are fully defined.
    for (int w = 0; w < NWORDS; w++) write_word(32'h3000 + 32'(4 * w), $urandom());

    // Preload then back-to-back fetch at LATENCY 0.
    write_word(32'h3000, 32'h3c01_1234);
    write_word(32'h3004, 32'h3421_5678);
    fetch_one(32'h3000);
    check("b2b.first.valid", {31'b0, rsp_valid[0]}, 32'h1);
    check("b2b.first.instr", rsp_instr[0], 32'h3c01_1234);
    fetch_one(32'h3004);
    check("b2b.second.valid", {31'b0, rsp_valid[0]}, 32'h1);
    check("b2b.second.instr", rsp_instr[0], 32'h3421_5678);
    check("b2b.second.err", {31'b0, rsp_err[0]}, 32'h0);
    idle_ticks(10);

    // LATENCY 3 timing and backpressure.
    req_valid = 1; req_addr = 32'h3004; rsp_ready = 0;
    tick();
    req_valid = 0;
    for (int k = 0; k < 9; k++) begin
      check($sformatf("lat3.valid.k%0d", k), {31'b0, rsp_valid[1]}, (k >= 3) ? 32'h1 : 32'h0);
      check($sformatf("lat3.ready.k%0d", k), {31'b0, req_ready[1]}, 32'h0);
      tick();
    end
    check("lat3.instr", rsp_instr[1], 32'h3421_5678);
    idle_ticks(10);

    // Error decoding.
    for (int e = 0; e < 4; e++) begin
      fetch_one(err_addrs[e]);
      idle_ticks(8);
      check($sformatf("err.%h", err_addrs[e]), {31'b0, rsp_err[2]}, {31'b0, err_exp[e]});
      if (err_exp[e]) check($sformatf("err.instr.%h", err_addrs[e]), rsp_instr[2], 32'h0);
    end

    // Same-edge write and fetch of one word.
    write_word(32'h3000, 32'h1111_1111);
    req_valid = 1; req_addr = 32'h3000; rsp_ready = 1;
    wr_en = 1; wr_addr = 32'h3000; wr_data = 32'h2222_2222;
    tick();
    wr_en = 0; req_valid = 0;
    check("rbw.old", rsp_instr[0], 32'h1111_1111);
    idle_ticks(8);
    fetch_one(32'h3000);
    check("rbw.new", rsp_instr[0], 32'h2222_2222);
    idle_ticks(8);

    // Reset while LATENCY 5 instance is waiting.
    fetch_one(32'h3008);
    tick(); tick();
    reset = 0;
    #1;
    check("mid_rst.valid", {31'b0, rsp_valid[2]}, 32'h0);
    check("mid_rst.addr", rsp_addr[2], 32'h0);
    model_clear();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    reset = 1;
    idle_ticks(10);
    fetch_one(32'h3008);
    idle_ticks(8);
    check("mid_rst.after", rsp_addr[2], 32'h3008);

`ifdef IMEM_FLUSH_EN
    req_valid = 1; req_addr = 32'h3004; rsp_ready = 0;
    tick();
    check("flush.pre", {31'b0, rsp_valid[0]}, 32'h1);
    req_valid = 1; req_addr = 32'h3000; flush = 1;
    tick();
    check("flush.drop", {31'b0, rsp_valid[0]}, 32'h0);
    flush = 0;
    tick();
    check("flush.accept", rsp_addr[0], 32'h3000);
    idle_ticks(10);
`endif

    // Randomised traffic.
    for (int k = 0; k < 3000; k++) begin
      req_valid = ($urandom_range(0, 99) < 60);
      req_addr  = rand_addr();
      rsp_ready = ($urandom_range(0, 99) < 70);
      wr_en     = ($urandom_range(0, 99) < 20);
      wr_addr   = rand_addr();
      wr_data   = $urandom();
      flush     = ($urandom_range(0, 99) < 5);
      tick();
    end
    idle_ticks(10);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/imem_responder.md
Name: imem_responder

Overview:
- Instruction-memory responder: the memory end of the instruction-fetch interface.
- Accepts fetch requests (byte PC) over a valid/ready channel and returns the 32-bit instruction word after a configurable number of wait states.
- Flags misaligned or out-of-range fetches.
- Includes a word write port so benches and the loader can preload program text.

Parameters:
- DEPTH_LOG2, 12, memory holds 2^DEPTH_LOG2 words.
- BASE_ADDR, 32'h0000_3000, byte address of word 0.
- LATENCY, 0, extra wait cycles before the response; legal range 0..7.

Ports:
- clk  input  1  single clock; all logic on the rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- req_valid  input  1  fetch request present.
- req_ready  output  1  responder can accept a request this cycle.
- req_addr  input  32  byte fetch address (PC).
- rsp_valid  output  1  response present.
- rsp_ready  input  1  requester takes the response this cycle.
- rsp_instr  output  32  instruction word; 0 when rsp_err=1.
- rsp_addr  output  32  echo of the accepted req_addr.
- rsp_err  output  1  accepted address was misaligned or out of range.
- wr_en  input  1  word write strobe.
- wr_addr  input  32  byte write address; decoded the same way as req_addr.
- wr_data  input  32  write data.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, wait counter=0.
  - rsp_valid=0, rsp_instr=0, rsp_addr=0, rsp_err=0.
  - Memory contents are not cleared.
  - A pending request or response is dropped immediately; no response is produced for it after reset releases.
- Address decode:
  - index = (addr - BASE_ADDR) >> 2.
  - err = (addr[1:0] != 0) || (addr < BASE_ADDR) || (addr >= BASE_ADDR + 4*2^DEPTH_LOG2).
  - 32-bit unsigned compares; the range end is computed 33 bits wide so there is no wrap at top of memory.
- States: IDLE, WAIT, RESP.
  - req_ready = (state==IDLE) || (state==RESP && rsp_ready), combinational.
  - Accept = req_valid && req_ready, on the rising edge.
- On accept:
  - Capture rsp_addr=req_addr and rsp_err=err.
  - Capture rsp_instr = err ? 0 : mem[index]. The read happens at the accept edge.
- Transitions:
  - IDLE -> RESP on accept when LATENCY=0.
  - IDLE -> WAIT on accept when LATENCY>0; counter loaded with LATENCY-1.
  - WAIT: counter decrements each cycle; -> RESP when counter==0.
  - RESP: rsp_valid=1. Outputs hold stable until rsp_ready=1.
    - On rsp_ready with a simultaneous accept: re-enter RESP (LATENCY=0) or WAIT (LATENCY>0) with the new capture.
    - On rsp_ready with no accept: -> IDLE, rsp_valid=0.
- Timing:
  - rsp_valid rises LATENCY+1 cycles after the accept edge.
  - Back-to-back throughput with LATENCY=0 is one fetch per cycle.
- rsp_valid is 0 in IDLE and WAIT. rsp_instr, rsp_addr and rsp_err keep their last values there.
- Writes:
  - mem[index] <= wr_data on any edge with wr_en=1 and err=0 for wr_addr.
  - Misaligned or out-of-range writes are silently ignored.
  - Writes are accepted in every state.
- Same-edge write and accept to the same word: the response carries the OLD word (read-before-write); the new word is visible from the next accept.
- req_addr and req_valid are ignored when req_ready=0; the requester must hold them.

Optional Feature:
- Macro IMEM_FLUSH_EN.
- Defined:
  - Adds input port flush (1 bit, synchronous).
  - flush=1 on an edge forces state=IDLE and rsp_valid=0, dropping any WAIT or RESP transaction.
  - A request presented in the same cycle as flush is not accepted: req_ready=0 while flush=1.
  - Used for branch/jump redirect.
- Not defined: no flush port; only reset aborts a transaction.

Test Plan:
- Preload, then fetch:
  - Write 32'h3c01_1234 to 32'h3000 and 32'h3421_5678 to 32'h3004.
  - LATENCY=0, fetch 32'h3000 then 32'h3004 back-to-back with rsp_ready=1.
  - -> rsp_valid on consecutive cycles; instr 32'h3c01_1234 then 32'h3421_5678; rsp_err=0.
- Wait states and backpressure:
  - LATENCY=3, fetch 32'h3004.
  - -> rsp_valid exactly 4 cycles after accept.
  - Hold rsp_ready=0 for 5 cycles -> outputs stable and req_ready=0 throughout.
- Errors:
  - Fetch 32'h3002 -> rsp_err=1, rsp_instr=0.
  - Fetch 32'h2ffc -> rsp_err=1.
  - Fetch 32'h3000+4*4096 -> rsp_err=1.
  - Fetch 32'h3000+4*4095 -> rsp_err=0.
- Same-edge write and read:
  - mem[0]=32'h1111_1111; in one cycle accept a fetch of 32'h3000 and write 32'h2222_2222 there.
  - -> response 32'h1111_1111; the next fetch returns 32'h2222_2222.
- Reset mid-operation:
  - LATENCY=5, accept a fetch, drive reset=0 for one cycle in WAIT.
  - -> rsp_valid=0 and rsp_addr=0 immediately; no response appears afterwards; the next fetch behaves normally.
- IMEM_FLUSH_EN:
  - Assert flush while in RESP -> rsp_valid=0 next cycle, state IDLE.
  - A request held with flush=1 is not accepted until flush=0.
